// File: rtl/sram_like_slave_pkg.sv
// Shared definitions for the sram_like responder: FSM states and transfer size codes.
package sram_like_slave_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int CNT_W = 3;

endpackage

// File: rtl/sram_be_decode.sv
// Maps an sram_like transfer size and the low address bits to SRAM byte-write enables.
module sram_be_decode
    import sram_like_slave_pkg::*;
(
    input  logic [1:0] i_size,
    input  logic [1:0] i_addrLo,
    output logic [3:0] o_byteEn
);

    // The reserved size code 11 falls through to a full-word access.
    always_comb begin
        o_byteEn = 4'b1111;
        case (i_size)
            SZ_BYTE: o_byteEn = 4'b0001 << i_addrLo;
            SZ_HALF: o_byteEn = i_addrLo[1] ? 4'b1100 : 4'b0011;
            default: o_byteEn = 4'b1111;
        endcase
    end

endmodule

// File: rtl/sram_like_slave.sv
// Responder end of the sram_like data port: one request at a time, optional wait
// cycles, a single SRAM access, then a one-cycle response that can overlap the next accept.
module sram_like_slave
    import sram_like_slave_pkg::*;
#(
    parameter int ADDR_W  = 14,
    parameter int LATENCY = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam bit              HAS_WAIT = (LATENCY > 0);
    localparam logic [CNT_W-1:0] CNT_INIT = HAS_WAIT ? CNT_W'(LATENCY - 1) : '0;

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic               r_wr;
    logic [ADDR_W-1:0]  r_addr;
    logic [3:0]         r_byteEn;
    logic [31:0]        r_wdata;
    logic               r_ramEn;
    logic [3:0]         r_ramWen;
    logic               r_dataOk;

    logic               w_transfer;
    logic [3:0]         w_byteEn;
    logic               w_unusedAddr;

    sram_be_decode u_beDecode (
        .i_size   (data_size),
        .i_addrLo (data_addr[1:0]),
        .o_byteEn (w_byteEn)
    );

    assign data_addr_ok = data_req & ((r_state == S_IDLE) | (r_state == S_RESP));
    assign w_transfer   = data_req & data_addr_ok;

    // High address bits are dropped on purpose so the RAM image wraps.
    assign w_unusedAddr = ^data_addr[31:ADDR_W+2];

    // Strobes are registered one state ahead so they line up exactly with ACCESS and RESP.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_byteEn <= 4'b0000;
            r_wdata  <= 32'd0;
            r_ramEn  <= 1'b0;
            r_ramWen <= 4'b0000;
            r_dataOk <= 1'b0;
        end else begin
            r_ramEn  <= 1'b0;
            r_ramWen <= 4'b0000;
            r_dataOk <= 1'b0;
            case (r_state)
                S_IDLE, S_RESP: begin
                    if (w_transfer) begin
                        r_wr     <= data_wr;
                        r_addr   <= data_addr[ADDR_W+1:2];
                        r_byteEn <= w_byteEn;
                        r_wdata  <= data_wdata;
                        if (HAS_WAIT) begin
                            r_state <= S_WAIT;
                            r_count <= CNT_INIT;
                        end else begin
                            r_state  <= S_ACCESS;
                            r_ramEn  <= 1'b1;
                            r_ramWen <= data_wr ? w_byteEn : 4'b0000;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (r_count == '0) begin
                        r_state  <= S_ACCESS;
                        r_ramEn  <= 1'b1;
                        r_ramWen <= r_wr ? r_byteEn : 4'b0000;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                S_ACCESS: begin
                    r_state  <= S_RESP;
                    r_dataOk <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ram_en       = r_ramEn;
    assign ram_wen      = r_ramWen;
    assign ram_addr     = r_addr;
    assign ram_wdata    = r_wdata;
    assign data_data_ok = r_dataOk;
    assign data_rdata   = (r_dataOk && !r_wr) ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_sram_like_slave.sv
// Bench for sram_like_slave: two instances (LATENCY 0 and 3) with behavioural RAMs,
// directed and randomized transfers checked against a lane-masked word-array reference.
module tb_sram_like_slave;

    logic        clk;
    logic        resetn;
    logic [1:0]  req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic        addrOk   [2];
    logic        dataOk   [2];
    logic [31:0] rdata    [2];
    logic        ramEn    [2];
    logic [3:0]  ramWen   [2];
    logic [13:0] ramAddr  [2];
    logic [31:0] ramWdata [2];
    logic [31:0] ramRdata [2];

    logic [31:0] mem    [2][16384];
    logic [31:0] refMem [2][16384];

    int          checks;
    int          passes;
    logic [31:0] lastRdata;

    sram_like_slave #(.ADDR_W(14), .LATENCY(0)) dutLat0 (
        .clk(clk), .resetn(resetn),
        .data_req(req[0]), .data_wr(wr), .data_size(size), .data_addr(addr), .data_wdata(wdata),
        .data_addr_ok(addrOk[0]), .data_data_ok(dataOk[0]), .data_rdata(rdata[0]),
        .ram_en(ramEn[0]), .ram_wen(ramWen[0]), .ram_addr(ramAddr[0]),
        .ram_wdata(ramWdata[0]), .ram_rdata(ramRdata[0])
    );

    sram_like_slave #(.ADDR_W(14), .LATENCY(3)) dutLat3 (
        .clk(clk), .resetn(resetn),
        .data_req(req[1]), .data_wr(wr), .data_size(size), .data_addr(addr), .data_wdata(wdata),
        .data_addr_ok(addrOk[1]), .data_data_ok(dataOk[1]), .data_rdata(rdata[1]),
        .ram_en(ramEn[1]), .ram_wen(ramWen[1]), .ram_addr(ramAddr[1]),
        .ram_wdata(ramWdata[1]), .ram_rdata(ramRdata[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous single-port RAM models: read data appears the cycle after ram_en.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ramEn[k]) begin
                ramRdata[k] <= mem[k][ramAddr[k]];
                for (int b = 0; b < 4; b++) begin
                    if (ramWen[k][b]) mem[k][ramAddr[k]][8*b +: 8] <= ramWdata[k][8*b +: 8];
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] laneMask(input logic [1:0] sz, input logic [31:0] a);
        logic [1:0] off;
        off = a[1:0];
        case (sz)
            2'b00:   laneMask = 32'h0000_00FF << (8 * off);
            2'b01:   laneMask = a[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            default: laneMask = 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [3:0] wenOf(input logic [31:0] m);
        wenOf = {m[24], m[16], m[8], m[0]};
    endfunction

    // Issues one request at a negedge where the DUT is IDLE or in RESP, keeps data_req
    // held through the whole transfer, and checks every cycle up to the response.
    task automatic applyStimulus(input int sel, input logic w, input logic [1:0] sz,
                                 input logic [31:0] a, input logic [31:0] d);
        int          word;
        int          lat;
        logic [31:0] m;
        word = int'((a >> 2) & 32'h3FFF);
        lat  = (sel == 0) ? 0 : 3;
        m    = laneMask(sz, a);
        req      = 2'b00;
        req[sel] = 1'b1;
        wr    = w;
        size  = sz;
        addr  = a;
        wdata = d;
        #1 checkOutput("accept", 32'(addrOk[sel]), 32'd1);
        @(posedge clk);
        for (int k = 1; k <= lat + 2; k++) begin
            @(negedge clk);
            checkOutput($sformatf("dataOk c%0d", k), 32'(dataOk[sel]), 32'(k == lat + 2));
            checkOutput($sformatf("ramEn c%0d", k), 32'(ramEn[sel]), 32'(k == lat + 1));
            checkOutput($sformatf("addrOkHeld c%0d", k), 32'(addrOk[sel]), 32'(k == lat + 2));
            if (k == lat + 1) begin
                checkOutput("ramWen", 32'(ramWen[sel]), w ? 32'(wenOf(m)) : 32'd0);
                checkOutput("ramAddr", 32'(ramAddr[sel]), 32'(word));
                if (w) checkOutput("ramWdata", ramWdata[sel], d);
            end else begin
                checkOutput("ramWenIdle", 32'(ramWen[sel]), 32'd0);
            end
            if (k == lat + 2) begin
                lastRdata = rdata[sel];
                checkOutput("rdata", rdata[sel], w ? 32'd0 : refMem[sel][word]);
            end
        end
        if (w) refMem[sel][word] = (refMem[sel][word] & ~m) | (d & m);
    endtask

    task automatic checkQuiet(input string tag);
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("%s dataOk%0d", tag, k), 32'(dataOk[k]), 32'd0);
            checkOutput($sformatf("%s ramEn%0d", tag, k), 32'(ramEn[k]), 32'd0);
            checkOutput($sformatf("%s ramWen%0d", tag, k), 32'(ramWen[k]), 32'd0);
            checkOutput($sformatf("%s rdata%0d", tag, k), rdata[k], 32'd0);
        end
    endtask

    // Write to word 5 on the LATENCY=3 instance, then pull reset while it is waiting.
    task automatic applyResetMidWait();
        req   = 2'b10;
        wr    = 1'b1;
        size  = 2'b10;
        addr  = 32'h0000_0014;
        wdata = ~refMem[1][5];
        #1 checkOutput("rstAccept", 32'(addrOk[1]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rstInWait", 32'(dataOk[1] | ramEn[1]), 32'd0);
        resetn = 1'b0;
        req    = 2'b00;
        #1 checkQuiet("midReset");
        repeat (4) begin
            @(negedge clk);
            checkOutput("rstHold dataOk", 32'(dataOk[1]), 32'd0);
            checkOutput("rstHold ramEn", 32'(ramEn[1]), 32'd0);
        end
        resetn = 1'b1;
    endtask

    initial begin
        logic        w;
        logic [1:0]  sz;
        logic [31:0] a;
        checks    = 0;
        passes    = 0;
        lastRdata = 32'd0;
        resetn = 1'b0;
        req    = 2'b00;
        wr     = 1'b0;
        size   = 2'b00;
        addr   = 32'd0;
        wdata  = 32'd0;
        repeat (3) @(negedge clk);
        checkQuiet("reset");
        resetn = 1'b1;

        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 16; i++)
                applyStimulus(s, 1'b1, 2'b10, 32'(i) << 2, $urandom);

        applyStimulus(0, 1'b1, 2'b10, 32'h0000_0100, 32'h1234_5678);
        applyStimulus(0, 1'b0, 2'b10, 32'h0000_0100, 32'd0);
        checkOutput("raw 0x100", lastRdata, 32'h1234_5678);

        applyStimulus(0, 1'b1, 2'b10, 32'h0000_0200, 32'h1122_3344);
        applyStimulus(0, 1'b1, 2'b00, 32'h0000_0201, 32'h0000_AB00);
        applyStimulus(0, 1'b1, 2'b01, 32'h0000_0202, 32'hCD00_0000);
        applyStimulus(0, 1'b0, 2'b10, 32'h0000_0200, 32'd0);
        checkOutput("lanes 0x200", lastRdata, 32'hCD00_AB44);

        applyStimulus(0, 1'b1, 2'b10, 32'h0001_0000, 32'hCAFE_F00D);
        applyStimulus(0, 1'b0, 2'b10, 32'h0000_0000, 32'd0);
        checkOutput("wrap 0x0", lastRdata, 32'hCAFE_F00D);

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 40; i++) begin
                w  = 1'($urandom_range(0, 1));
                sz = 2'($urandom_range(0, 3));
                a  = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 15)) << 2)
                     | 32'($urandom_range(0, 3));
                applyStimulus(s, w, sz, a, $urandom);
            end
        end

        applyResetMidWait();
        applyStimulus(1, 1'b0, 2'b10, 32'h0000_0014, 32'd0);
        applyStimulus(1, 1'b1, 2'b10, 32'h0000_0014, 32'hA5A5_5A5A);
        applyStimulus(1, 1'b0, 2'b10, 32'h0000_0014, 32'd0);
        checkOutput("postReset rd", lastRdata, 32'hA5A5_5A5A);

        req = 2'b00;
        repeat (2) @(negedge clk);
        checkQuiet("idle");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
